bit_serial_alu: RTL and testbench



---
 rtl/bit_serial_alu.sv | 175 +++++++++++++++++
 tb/tb_bit_serial_alu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu.sv
// ============================================================================
//  Module   : bit_serial_alu (with leaf cell alu1bit)
//  Purpose  : Multi-cycle ALU that runs one alu1bit cell once per clock,
//             LSB first, over a WIDTH-bit operand pair. It uses the same op
//             encoding as the parallel ALU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
//  alu1bit : single-bit ALU slice (AND / OR / ADD / LESS), with optional b invert
// ----------------------------------------------------------------------------
module alu1bit (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] op,
    output logic       result,
    output logic       cout
);
    logic w_bb;
    logic w_sum;

    assign w_bb  = b ^ op[2];
    assign w_sum = a ^ w_bb ^ cin;
    assign cout  = (a & w_bb) | (a & cin) | (w_bb & cin);

    // Select the slice result from the low op bits
    always_comb begin
        result = 1'b0;
        case (op[1:0])
            2'b00:   result = a & w_bb;
            2'b01:   result = a | w_bb;
            2'b10:   result = w_sum;
            default: result = less;
        endcase
    end
endmodule

// ----------------------------------------------------------------------------
//  bit_serial_alu : sequencer around one alu1bit
// ----------------------------------------------------------------------------
module bit_serial_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [2:0] C_OP_SLT = 3'b111;
    localparam logic [2:0] C_OP_SUB = 3'b110;

    // FIN is the single cycle that resolves the flags and SLT after the MSB
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_cin_msb;
    logic             r_cout_msb;
    logic             r_set;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_cell_res;
    logic             w_cell_cout;
    logic [2:0]       w_cell_op;
    logic [WIDTH-1:0] w_final;
    logic             w_arith;
    logic             w_is_slt;

    // SLT runs through the subtract path; the set bit is formed afterwards
    assign w_is_slt  = (r_op == C_OP_SLT);
    assign w_cell_op = w_is_slt ? C_OP_SUB : r_op;
    assign w_arith   = (r_op[1:0] == 2'b10);
    assign w_final   = w_is_slt ? {{(WIDTH-1){1'b0}}, r_set} : r_res_sh;

    alu1bit u_cell (
        .a      (r_a_sh[0]),
        .b      (r_b_sh[0]),
        .cin    (r_carry),
        .less   (1'b0),
        .op     (w_cell_op),
        .result (w_cell_res),
        .cout   (w_cell_cout)
    );

    // Sequencer: latch, shift one bit per cycle, then resolve flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_op       <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_cin_msb  <= 1'b0;
            r_cout_msb <= 1'b0;
            r_set      <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_op    <= op;
                        r_carry <= op[2];
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_res_sh <= {w_cell_res, r_res_sh[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_cell_cout;
                    r_idx    <= r_idx + 1'b1;
                    if (r_idx == C_IDX_LAST) begin
                        r_cin_msb  <= r_carry;
                        r_cout_msb <= w_cell_cout;
                        r_set      <= w_cell_res ^ (r_carry ^ w_cell_cout);
                        r_state    <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_result <= w_final;
                    r_zero   <= ~|w_final;
                    r_cout   <= w_arith & r_cout_msb;
                    r_ovf    <= w_arith & (r_cin_msb ^ r_cout_msb);
                    r_state  <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;
endmodule

`default_nettype wire

// File: tb/tb_bit_serial_alu.sv
// ============================================================================
//  Module   : tb_bit_serial_alu
//  Purpose  : Self-checking bench for bit_serial_alu at WIDTH=8.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_alu;
    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       z;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    int n_cmp = 0;
    int n_err = 0;
    vec_t sb_q[$];

    bit_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference for randomised operations
    function automatic vec_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
        vec_t v;
        logic [8:0] s;
        v.a = ma; v.b = mb; v.op = mop; v.res = '0; v.co = 1'b0; v.ov = 1'b0;
        case (mop)
            3'b000: v.res = ma & mb;
            3'b100: v.res = ma & ~mb;
            3'b001: v.res = ma | mb;
            3'b010: begin
                s = {1'b0, ma} + {1'b0, mb};
                v.res = s[7:0]; v.co = s[8];
                v.ov = (ma[7] == mb[7]) && (s[7] != ma[7]);
            end
            3'b110: begin
                s = {1'b0, ma} - {1'b0, mb};
                v.res = s[7:0]; v.co = (ma >= mb);
                v.ov = (ma[7] != mb[7]) && (s[7] != ma[7]);
            end
            default: v.res = ($signed(ma) < $signed(mb)) ? 8'h01 : 8'h00;
        endcase
        v.z = (v.res == 8'h00);
        return v;
    endfunction

    // Launch one op, optionally pulse spurious starts on RUN cycles 3 and 5
    task automatic run_op(input vec_t v, input bit spurious);
        int lat;
        int ndone;
        vec_t e;
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; start = 1'b1;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
        lat = 0;
        ndone = 0;
        for (int c = 1; c <= WIDTH + 6; c++) begin
            @(posedge clk);
            #1;
            start = (spurious && (c == 2 || c == 4)) ? 1'b1 : 1'b0;
            if (start) begin a = 8'h55; b = 8'hAA; op = 3'b001; end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    lat = c;
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL scoreboard: got done with empty queue expected pending entry");
                    end else begin
                        e = sb_q.pop_front();
                        chk("result", 64'(result), 64'(e.res));
                        chk("cout", 64'(cout), 64'(e.co));
                        chk("overflow", 64'(overflow), 64'(e.ov));
                        chk("zero", 64'(zero), 64'(e.z));
                    end
                end
            end
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'(WIDTH + 1));
        chk("done_pulses", 64'(ndone), 64'd1);
    endtask

    vec_t tbl[12];
    vec_t rv;
    logic [2:0] ops[6];
    int ndone_rst;

    initial begin
        tbl[0]  = '{8'h7F, 8'h01, 3'b010, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{8'h05, 8'h05, 3'b110, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{8'hFF, 8'h01, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{8'h80, 8'h01, 3'b111, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h01, 8'h80, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{8'h7F, 8'h80, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{8'hF0, 8'h30, 3'b100, 8'hC0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8'h0F, 8'hA0, 3'b001, 8'hAF, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h0F, 8'hA0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{8'h03, 8'h05, 3'b110, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{8'h80, 8'h01, 3'b110, 8'h7F, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{8'h03, 8'h04, 3'b010, 8'h07, 1'b0, 1'b0, 1'b0};
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100};

        // Reset state, with start held high to show reset dominates
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_op(tbl[i], 1'b0);

        for (int i = 0; i < 10; i++) begin
            rv = model(8'($urandom), 8'($urandom), ops[$urandom_range(0, 5)]);
            run_op(rv, 1'b0);
        end

        // Spurious starts during RUN must be ignored
        run_op(tbl[0], 1'b1);

        // Reset on RUN cycle 4 aborts and clears the outputs
        @(negedge clk);
        a = 8'h11; b = 8'h22; op = 3'b010; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_zero", 64'(zero), 64'd1);
        chk("abort_overflow", 64'(overflow), 64'd0);
        ndone_rst = 0;
        for (int c = 0; c < WIDTH + 6; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone_rst++;
        end
        chk("abort_no_done", 64'(ndone_rst), 64'd0);

        run_op(tbl[11], 1'b0);

        chk("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
